change_dispenser: RTL

- Sits directly downstream of the vending controller.
- Takes the change balance (cents) the controller releases and pays it out as dollar and quarter coins through a coin hopper, using a per-coin request/acknowledge handshake.
- Tracks coin inventory, substitutes quarters when dollars run out, and detects hopper jams by timeout.
- Reports completion, shortfall and undispensable residue back to the controller.

---
 rtl/change_dispenser.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change balance as dollar and quarter coins
// through a coin hopper using a per-coin request/acknowledge handshake.
// Tracks coin inventory, falls back to quarters when dollars run out,
// declares a jam when the hopper stops acknowledging, and reports the
// unpaid balance (including any sub-quarter residue) back to the vending
// controller.
//
// Optional feature: define CHANGE_DISPENSER_STATS_EN to add the 16-bit
// coins_total output, a saturating count of acknowledged coins since reset.

module change_dispenser #(
   parameter int AMT_W          = 12,
   parameter int INV_W          = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int GAP_CYCLES     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             coin_ack,
   input  logic             load_dollar,
   input  logic             load_quarter,
   input  logic             clear_jam,
   output logic             coin_req,
   output logic             coin_sel,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] change_left,
   output logic             jam,
   output logic [INV_W-1:0] dollar_cnt,
   output logic [INV_W-1:0] quarter_cnt
`ifdef CHANGE_DISPENSER_STATS_EN
   ,
   output logic [15:0]      coins_total
`endif
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

   localparam logic [AMT_W-1:0]   DOLLAR_VALUE  = AMT_W'(100);
   localparam logic [AMT_W-1:0]   QUARTER_VALUE = AMT_W'(25);
   localparam logic [INV_W-1:0]   INV_FULL      = {INV_W{1'b1}};
   localparam logic [TIMER_W-1:0] TIMER_LAST    = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST      = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      REQ,
      GAP,
      DONE,
      JAM
   } state_t;

   state_t             state_q;
   logic [AMT_W-1:0]   remaining_q;
   logic [TIMER_W-1:0] timer_q;
   logic [GAP_W-1:0]   gap_q;
   logic [INV_W-1:0]   dollarCnt_q;
   logic [INV_W-1:0]   quarterCnt_q;
   logic               coinReq_q;
   logic               coinSel_q;
   logic               busy_q;
   logic               done_q;
   logic               short_q;
   logic [AMT_W-1:0]   changeLeft_q;
   logic               jam_q;

   logic               canDollar;
   logic               canQuarter;
   logic               ackAccepted;
   logic [AMT_W-1:0]   remaining_d;

   // Coin choice for the next request and the balance left once the coin
   // currently being requested has been acknowledged.
   always_comb begin
      canDollar   = (remaining_q >= DOLLAR_VALUE) && (dollarCnt_q != '0);
      canQuarter  = (remaining_q >= QUARTER_VALUE) && (quarterCnt_q != '0);
      ackAccepted = (state_q == REQ) && coin_ack;
      remaining_d = remaining_q - (coinSel_q ? DOLLAR_VALUE : QUARTER_VALUE);
   end

   // Payout state machine; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         timer_q      <= '0;
         gap_q        <= '0;
         dollarCnt_q  <= INV_FULL;
         quarterCnt_q <= INV_FULL;
         coinReq_q    <= 1'b0;
         coinSel_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         short_q      <= 1'b0;
         changeLeft_q <= '0;
         jam_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  remaining_q <= amount;
                  busy_q      <= 1'b1;
                  state_q     <= SELECT;
               end
               if (load_dollar) begin
                  dollarCnt_q <= INV_FULL;
               end
               if (load_quarter) begin
                  quarterCnt_q <= INV_FULL;
               end
            end
            SELECT: begin
               if (canDollar) begin
                  coinSel_q <= 1'b1;
                  coinReq_q <= 1'b1;
                  timer_q   <= '0;
                  state_q   <= REQ;
               end else if (canQuarter) begin
                  coinSel_q <= 1'b0;
                  coinReq_q <= 1'b1;
                  timer_q   <= '0;
                  state_q   <= REQ;
               end else begin
                  done_q       <= 1'b1;
                  changeLeft_q <= remaining_q;
                  short_q      <= (remaining_q >= QUARTER_VALUE);
                  state_q      <= DONE;
               end
            end
            REQ: begin
               if (coin_ack) begin
                  coinReq_q   <= 1'b0;
                  remaining_q <= remaining_d;
                  timer_q     <= '0;
                  gap_q       <= '0;
                  state_q     <= GAP;
                  if (coinSel_q) begin
                     if (dollarCnt_q != '0) begin
                        dollarCnt_q <= dollarCnt_q - 1'b1;
                     end
                  end else begin
                     if (quarterCnt_q != '0) begin
                        quarterCnt_q <= quarterCnt_q - 1'b1;
                     end
                  end
               end else if (timer_q == TIMER_LAST) begin
                  coinReq_q <= 1'b0;
                  busy_q    <= 1'b0;
                  jam_q     <= 1'b1;
                  timer_q   <= '0;
                  state_q   <= JAM;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            GAP: begin
               if (gap_q == GAP_LAST) begin
                  gap_q   <= '0;
                  state_q <= SELECT;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            JAM: begin
               if (clear_jam) begin
                  jam_q        <= 1'b0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b1;
                  changeLeft_q <= remaining_q;
                  short_q      <= 1'b1;
                  state_q      <= DONE;
               end
            end
            default: begin
               coinReq_q <= 1'b0;
               busy_q    <= 1'b0;
               jam_q     <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

`ifdef CHANGE_DISPENSER_STATS_EN
   logic [15:0] coinsTotal_q;

   // Saturating tally of every coin the hopper has acknowledged since reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         coinsTotal_q <= '0;
      end else if (ackAccepted && (coinsTotal_q != 16'hFFFF)) begin
         coinsTotal_q <= coinsTotal_q + 16'd1;
      end
   end

   assign coins_total = coinsTotal_q;
`else
   logic unusedAck;
   assign unusedAck = ackAccepted;
`endif

   assign coin_req    = coinReq_q;
   assign coin_sel    = coinSel_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign short       = short_q;
   assign change_left = changeLeft_q;
   assign jam         = jam_q;
   assign dollar_cnt  = dollarCnt_q;
   assign quarter_cnt = quarterCnt_q;

endmodule
